// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - sequencer that serializes a test word into a 1101 Moore detector and tallies its hits
//
// Purpose:
//   Accepts a parallel word and length, clears the attached detector, shifts the
//   word MSB-first (data[len-1] first) into it one bit per clock, and records how
//   many cycles the detector reported a hit and at which bit the first hit completed.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   start              run request, honoured only while idle
//   data, len          word to send and number of bits (len > WIDTH is clamped)
//   busy               high whenever a run is in progress
//   done               one-cycle pulse when the results below are final
//   hit_count          number of sampled hit cycles (saturating)
//   hit_any            at least one hit was seen
//   first_hit_idx      index (0 = first bit sent) of the bit that completed the first hit
//   det_reset, det_inp drive the detector's reset and serial input
//   det_y              detector Moore output
//
// Build option:
//   SEQ_DET_CTRL_STOP_ON_HIT_EN - when defined, the first sampled hit ends the run
//   and the FSM jumps straight to DONE.

module seq_det_ctrl #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1),
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CW-1:0]    len,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    hit_count,
  output logic             hit_any,
  output logic [IW-1:0]    first_hit_idx,
  output logic             det_reset,
  output logic             det_inp,
  input  logic             det_y
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    len_q, len_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CW-1:0]    hit_count_q, hit_count_d;
  logic             hit_any_q, hit_any_d;
  logic [IW-1:0]    first_hit_idx_q, first_hit_idx_d;

  logic             sample_hit;
  logic [IW-1:0]    attr_idx;
  logic [IW-1:0]    bit_sel;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      word_q          <= '0;
      len_q           <= '0;
      k_q             <= '0;
      hit_count_q     <= '0;
      hit_any_q       <= 1'b0;
      first_hit_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      word_q          <= word_d;
      len_q           <= len_d;
      k_q             <= k_d;
      hit_count_q     <= hit_count_d;
      hit_any_q       <= hit_any_d;
      first_hit_idx_q <= first_hit_idx_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d         = state_q;
    word_d          = word_q;
    len_d           = len_q;
    k_d             = k_q;
    hit_count_d     = hit_count_q;
    hit_any_d       = hit_any_q;
    first_hit_idx_d = first_hit_idx_q;
    sample_hit      = 1'b0;
    attr_idx        = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_d          = data;
          len_d           = (len > CW'(WIDTH)) ? CW'(WIDTH) : len;
          k_d             = '0;
          hit_count_d     = '0;
          hit_any_d       = 1'b0;
          first_hit_idx_d = '0;
          state_d         = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = (len_q != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        // Moore output lags the input by one cycle: at bit k it reports the
        // history up to bit k-1, so nothing meaningful exists at k == 0.
        sample_hit = (k_q != '0) && det_y;
        attr_idx   = IW'(k_q - CW'(1));
        k_d        = k_q + CW'(1);
        if (k_q == len_q - CW'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Extra cycle to observe the response to the last bit sent.
        sample_hit = det_y;
        attr_idx   = IW'(len_q - CW'(1));
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (sample_hit) begin
      if (hit_count_q != '1) begin
        hit_count_d = hit_count_q + CW'(1);
      end
      if (!hit_any_q) begin
        hit_any_d       = 1'b1;
        first_hit_idx_d = attr_idx;
      end
`ifdef SEQ_DET_CTRL_STOP_ON_HIT_EN
      state_d = S_DONE;
`else
`endif
    end
  end

  // Outputs
  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    det_reset     = reset || (state_q == S_CLEAR);
    bit_sel       = IW'(len_q - CW'(1) - k_q);
    det_inp       = (state_q == S_SHIFT) ? word_q[bit_sel] : 1'b0;
    hit_count     = hit_count_q;
    hit_any       = hit_any_q;
    first_hit_idx = first_hit_idx_q;
  end

endmodule
